// File: rtl/cic_pkg.sv
// rtl/cic_pkg.sv - shared CIC decimator constants and controller state type
package cic_pkg;

  localparam int CIC_NUM_STAGES = 3;
  localparam int CIC_STG_GSZ    = 5;
  localparam int CIC_ISZ        = 16;
  localparam int CIC_OSZ        = CIC_ISZ + CIC_NUM_STAGES * CIC_STG_GSZ;

  typedef enum logic [1:0] {
    HOLD,
    FLUSH,
    RUN
  } cic_ctrl_state_t;

endpackage

// File: rtl/sample_fifo.sv
// rtl/sample_fifo.sv - synchronous sample FIFO with a registered read head
module sample_fifo #(
  parameter int W     = 16,
  parameter int DEPTH = 4
) (
  input  logic         in_clk,
  input  logic         reset,
  input  logic         wr_en,
  input  logic [W-1:0] wr_data,
  input  logic         rd_en,
  output logic         full,
  output logic         empty,
  output logic [W-1:0] rd_data
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr, rd_ptr_nx;
  logic [AW:0]   count, count_nx;
  logic          rd_ok, wr_ok;

  assign full  = (count == (AW+1)'(DEPTH));
  assign empty = (count == '0);

  always_comb begin
    rd_ok     = rd_en && !empty;
    wr_ok     = wr_en && (!full || rd_ok);
    count_nx  = count + (AW+1)'(wr_ok) - (AW+1)'(rd_ok);
    rd_ptr_nx = rd_ptr + AW'(rd_ok);
  end

  always_ff @(posedge in_clk) begin
    if (wr_ok) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge in_clk) begin
    if (reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      rd_data <= '0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + AW'(1);
      rd_ptr <= rd_ptr_nx;
      count  <= count_nx;
      // a write that lands as the only entry bypasses the array into the head
      if (wr_ok && count_nx == (AW+1)'(1)) rd_data <= wr_data;
      else if (rd_ok && count_nx != '0)    rd_data <= mem[rd_ptr_nx];
    end
  end

endmodule

// File: rtl/cic_decim_ctrl.sv
// rtl/cic_decim_ctrl.sv - CIC decimator sequencer, output scaler and sample buffer
module cic_decim_ctrl
  import cic_pkg::*;
#(
  parameter int ISZ        = CIC_ISZ,
  parameter int OSZ        = CIC_OSZ,
  parameter int CNT_W      = 8,
  parameter int DISCARD    = 3,
  parameter int FIFO_DEPTH = 4
) (
  input  logic             in_clk,
  input  logic             reset,
  input  logic [CNT_W-1:0] cfg_ratio,
  input  logic [4:0]       cfg_shift,
  input  logic             cfg_load,
  output logic             cfg_busy,
  output logic             cic_reset,
  output logic             cic_out_clk,
  input  logic [OSZ-1:0]   cic_out,
  input  logic             cic_out_valid,
  output logic [ISZ-1:0]   m_data,
  output logic             m_valid,
  input  logic             m_ready,
  output logic             sat_flag,
  output logic             ovf_flag,
  input  logic             flag_clr
);
  localparam int DW = $clog2(DISCARD + 2);
  localparam logic signed [OSZ-1:0] S_MAX = OSZ'((1 << (ISZ - 1)) - 1);
  localparam logic signed [OSZ-1:0] S_MIN = ~S_MAX;

  cic_ctrl_state_t       state;
  logic [1:0]            hold_cnt;
  logic [DW-1:0]         disc_cnt;
  logic [CNT_W-1:0]      ratio_q, dec_cnt;
  logic [4:0]            shift_q;
  logic                  take, sc_valid, sat_hit;
  logic                  fifo_full, fifo_empty, fifo_rd, fifo_wr;
  logic [ISZ-1:0]        sc_data, sat_val;
  logic signed [OSZ-1:0] shifted;

  assign take    = (state == RUN) && cic_out_valid && !cfg_load;
  assign fifo_rd = m_valid && m_ready;
  assign fifo_wr = sc_valid && (!fifo_full || fifo_rd);
  assign m_valid = !fifo_empty;

  always_comb begin
    shifted = $signed(cic_out) >>> shift_q;
    sat_hit = 1'b0;
    sat_val = shifted[ISZ-1:0];
    if (shifted > S_MAX) begin
      sat_val = {1'b0, {(ISZ-1){1'b1}}};
      sat_hit = 1'b1;
    end else if (shifted < S_MIN) begin
      sat_val = {1'b1, {(ISZ-1){1'b0}}};
      sat_hit = 1'b1;
    end
  end

  always_ff @(posedge in_clk) begin
    if (reset) begin
      state       <= HOLD;
      hold_cnt    <= 2'd2;
      disc_cnt    <= DW'(DISCARD);
      dec_cnt     <= '0;
      ratio_q     <= CNT_W'(2);
      shift_q     <= 5'd15;
      cic_reset   <= 1'b1;
      cic_out_clk <= 1'b0;
      cfg_busy    <= 1'b0;
    end else if (cfg_load) begin
      state       <= HOLD;
      hold_cnt    <= 2'd2;
      disc_cnt    <= DW'(DISCARD);
      dec_cnt     <= '0;
      ratio_q     <= (cfg_ratio < CNT_W'(2)) ? CNT_W'(2) : cfg_ratio;
      shift_q     <= cfg_shift;
      cic_reset   <= 1'b1;
      cic_out_clk <= 1'b0;
      cfg_busy    <= 1'b1;
    end else begin
      if (fifo_wr) cfg_busy <= 1'b0;
      if (state == HOLD) begin
        dec_cnt     <= '0;
        cic_out_clk <= 1'b0;
      end else if (dec_cnt == ratio_q - CNT_W'(1)) begin
        dec_cnt     <= '0;
        cic_out_clk <= 1'b1;
      end else begin
        dec_cnt     <= dec_cnt + CNT_W'(1);
        cic_out_clk <= 1'b0;
      end
      case (state)
        HOLD: begin
          disc_cnt <= DW'(DISCARD);
          if (hold_cnt == 2'd0) begin
            state     <= FLUSH;
            cic_reset <= 1'b0;
          end else begin
            hold_cnt <= hold_cnt - 2'd1;
          end
        end
        FLUSH: begin
          // comb-pipeline start-up words are counted off and never stored
          if (disc_cnt == '0) begin
            state <= RUN;
          end else if (cic_out_valid) begin
            disc_cnt <= disc_cnt - DW'(1);
            if (disc_cnt == DW'(1)) state <= RUN;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge in_clk) begin
    if (reset) begin
      sc_valid <= 1'b0;
      sc_data  <= '0;
      sat_flag <= 1'b0;
      ovf_flag <= 1'b0;
    end else begin
      sc_valid <= take;
      if (take) sc_data <= sat_val;
      if (take && sat_hit)      sat_flag <= 1'b1;
      else if (flag_clr)        sat_flag <= 1'b0;
      if (sc_valid && !fifo_wr) ovf_flag <= 1'b1;
      else if (flag_clr)        ovf_flag <= 1'b0;
    end
  end

  sample_fifo #(
    .W     (ISZ),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .in_clk  (in_clk),
    .reset   (reset),
    .wr_en   (sc_valid),
    .wr_data (sc_data),
    .rd_en   (fifo_rd),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .rd_data (m_data)
  );

endmodule

// File: tb/tb_cic_decim_ctrl.sv
// tb/tb_cic_decim_ctrl.sv - randomized self-checking bench for cic_decim_ctrl
module tb_cic_decim_ctrl;
  localparam int DEPTH   = 4;
  localparam int DISCARD = 3;

  logic        in_clk = 1'b0;
  logic        reset;
  logic [7:0]  cfg_ratio;
  logic [4:0]  cfg_shift;
  logic        cfg_load;
  logic        cfg_busy;
  logic        cic_reset;
  logic        cic_out_clk;
  logic [30:0] cic_out;
  logic        cic_out_valid;
  logic [15:0] m_data;
  logic        m_valid;
  logic        m_ready;
  logic        sat_flag;
  logic        ovf_flag;
  logic        flag_clr;

  always #5 in_clk = ~in_clk;

  cic_decim_ctrl dut (
    .in_clk        (in_clk),
    .reset         (reset),
    .cfg_ratio     (cfg_ratio),
    .cfg_shift     (cfg_shift),
    .cfg_load      (cfg_load),
    .cfg_busy      (cfg_busy),
    .cic_reset     (cic_reset),
    .cic_out_clk   (cic_out_clk),
    .cic_out       (cic_out),
    .cic_out_valid (cic_out_valid),
    .m_data        (m_data),
    .m_valid       (m_valid),
    .m_ready       (m_ready),
    .sat_flag      (sat_flag),
    .ovf_flag      (ovf_flag),
    .flag_clr      (flag_clr)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input longint obs, input longint exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", tag, obs, obs, exp, exp, $time);
    end
  endtask

  // reference model state: timeline of the spec, FIFO as a queue
  int          m_ratio, m_shift, hold_left, drop_left, cyc, deassert_cyc, n_acc;
  logic [15:0] fifo_q[$];
  bit          infl_v, e_busy, e_sat, e_ovf;
  logic [15:0] infl_d;

  // stimulus knobs
  int          rdy_pct, xv_pct, clr_pct, ld_ratio, ld_shift;
  bit          do_load, ld_on_strobe, use_fix;
  logic [30:0] fix_val;

  function automatic logic [16:0] model_scale(input logic [30:0] raw, input int sh);
    longint v, d, q;
    v = longint'($signed(raw));
    d = longint'(1) << sh;
    q = v / d;
    if ((v % d != 0) && (v < 0)) q = q - 1;
    if (q > 32767)  return {1'b1, 16'h7FFF};
    if (q < -32768) return {1'b1, 16'h8000};
    return {1'b0, q[15:0]};
  endfunction

  task automatic step();
    bit          exp_strobe, new_v;
    int          since;
    logic [30:0] raw;
    logic [16:0] sc;
    @(posedge in_clk);
    #1;
    cyc++;
    since      = cyc - deassert_cyc;
    exp_strobe = (hold_left == 0) && (since >= m_ratio) && (since % m_ratio == 0);
    check("cic_reset", cic_reset, hold_left > 0);
    check("cic_out_clk", cic_out_clk, exp_strobe);
    check("m_valid", m_valid, fifo_q.size() != 0);
    if (fifo_q.size() != 0) check("m_data", m_data, fifo_q[0]);
    check("cfg_busy", cfg_busy, e_busy);
    check("sat_flag", sat_flag, e_sat);
    check("ovf_flag", ovf_flag, e_ovf);

    m_ready  = ($urandom_range(99) < rdy_pct);
    flag_clr = ($urandom_range(99) < clr_pct);
    cfg_load = do_load && (!ld_on_strobe || cic_out_clk);
    if (cfg_load) begin
      cfg_ratio = ld_ratio[7:0];
      cfg_shift = ld_shift[4:0];
      do_load   = 1'b0;
    end
    new_v         = cic_out_clk || ($urandom_range(99) < xv_pct);
    raw           = use_fix ? fix_val : 31'($urandom);
    cic_out_valid = new_v;
    cic_out       = raw;

    if (m_ready && fifo_q.size() != 0) void'(fifo_q.pop_front());
    if (flag_clr) begin
      e_sat = 1'b0;
      e_ovf = 1'b0;
    end
    if (infl_v) begin
      if (fifo_q.size() < DEPTH) begin
        fifo_q.push_back(infl_d);
        e_busy = 1'b0;
      end else begin
        e_ovf = 1'b1;
      end
      infl_v = 1'b0;
    end
    if (new_v && !cfg_load && hold_left == 0) begin
      if (drop_left > 0) begin
        drop_left--;
      end else begin
        sc     = model_scale(raw, m_shift);
        infl_v = 1'b1;
        infl_d = sc[15:0];
        if (sc[16]) e_sat = 1'b1;
        n_acc++;
      end
    end
    if (hold_left > 0) begin
      hold_left--;
      if (hold_left == 0) deassert_cyc = cyc + 1;
    end
    if (cfg_load) begin
      hold_left = 3;
      drop_left = DISCARD;
      e_busy    = 1'b1;
      m_ratio   = (ld_ratio < 2) ? 2 : ld_ratio;
      m_shift   = ld_shift;
    end
  endtask

  task automatic load(input int r, input int s, input bit on_strobe);
    do_load      = 1'b1;
    ld_ratio     = r;
    ld_shift     = s;
    ld_on_strobe = on_strobe;
    for (int i = 0; i < 300 && do_load; i++) step();
    if (do_load) begin
      check("load_timeout", 0, 1);
      do_load = 1'b0;
    end
  endtask

  initial begin
    int acc0;
    reset = 1'b1; cfg_ratio = '0; cfg_shift = '0; cfg_load = 1'b0;
    cic_out = '0; cic_out_valid = 1'b0; m_ready = 1'b1; flag_clr = 1'b0;
    do_load = 1'b0; use_fix = 1'b0; fix_val = '0;
    rdy_pct = 100; xv_pct = 0; clr_pct = 0;
    repeat (4) @(posedge in_clk);
    #1;
    check("rst_cic_reset", cic_reset, 1);
    check("rst_out_clk", cic_out_clk, 0);
    check("rst_m_valid", m_valid, 0);
    check("rst_m_data", m_data, 0);
    check("rst_busy", cfg_busy, 0);
    check("rst_sat", sat_flag, 0);
    check("rst_ovf", ovf_flag, 0);
    reset = 1'b0;
    m_ratio = 2; m_shift = 15; hold_left = 2; drop_left = DISCARD;
    cyc = 0; deassert_cyc = 0; n_acc = 0;
    infl_v = 1'b0; e_busy = 1'b0; e_sat = 1'b0; e_ovf = 1'b0;

    // default ratio after reset
    repeat (60) step();

    // ratio 32, DC input
    use_fix = 1'b1; fix_val = 31'(1000 << 15);
    load(32, 15, 1'b0);
    repeat (32 * 10) step();
    check("dc_m_data", m_data, 1000);

    // positive and negative saturation, flag clear
    fix_val = 31'h3FFF_FFFF;
    load(2, 0, 1'b0);
    repeat (30) step();
    check("sat_pos_data", m_data, 16'h7FFF);
    check("sat_pos_flag", sat_flag, 1);
    fix_val = 31'd5;
    repeat (6) step();
    clr_pct = 100; step(); clr_pct = 0;
    repeat (4) step();
    check("sat_cleared", sat_flag, 0);
    fix_val = 31'h4000_0000;
    repeat (10) step();
    check("sat_neg_data", m_data, 16'h8000);
    check("sat_neg_flag", sat_flag, 1);

    // backpressure at ratio 2
    use_fix = 1'b0;
    load(2, 15, 1'b0);
    repeat (30) step();
    rdy_pct = 0;
    acc0 = n_acc;
    for (int i = 0; i < 100 && (n_acc - acc0) < 6; i++) step();
    check("bp_words_seen", n_acc - acc0, 6);
    repeat (2) step();
    check("bp_ovf", ovf_flag, 1);
    check("bp_m_valid", m_valid, 1);
    rdy_pct = 100;
    repeat (20) step();
    clr_pct = 100; step(); clr_pct = 0;

    // reconfiguration coinciding with a CIC word, with words queued
    rdy_pct = 0;
    repeat (6) step();
    load(8, 15, 1'b1);
    rdy_pct = 100;
    repeat (8 * 12) step();

    // ratio clamp
    load(0, 15, 1'b0);
    repeat (40) step();
    load(1, 15, 1'b0);
    repeat (40) step();

    // randomized configurations and traffic
    for (int k = 0; k < 8; k++) begin
      rdy_pct = $urandom_range(30, 100);
      xv_pct  = $urandom_range(0, 15);
      clr_pct = 5;
      load($urandom_range(0, 12), $urandom_range(8, 20), 1'($urandom_range(1)));
      repeat (150) step();
    end
    rdy_pct = 100; xv_pct = 0; clr_pct = 0;
    repeat (20) step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
